vq_codebook_search: RTL

//  Sequences the read port of the 16x13 LBG VQ codebook RAM (14-bit words, 1-cycle read latency, no output reg).

---
 rtl/vq_codebook_search.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vq_codebook_search.sv
// ---------------------------------------------------------------------------
// vq_codebook_search
//   Nearest-codeword search for a vector quantiser. The block buffers one
//   DIM-sample feature vector, then drives the read port of the codebook RAM
//   through every word of all NUM_CW codewords. For each codeword it
//   accumulates the squared Euclidean distance and keeps the smallest one.
//   Ties keep the lowest index. It returns the index and distance of the
//   nearest codeword and holds them until the result is consumed.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   abort                  synchronous clear back to LOAD, wins over all else
//   s_data/s_valid/s_ready feature sample input (accepted in LOAD only)
//   cb_rd_addr/cb_rd_en    codebook RAM read request
//   cb_rd_data             RAM read data, one cycle after its address
//   busy                   high while scanning (SEARCH and DRAIN)
//   res_idx/res_dist       nearest codeword index and squared distance
//   res_valid/res_ready    result handshake, result held until consumed
// ---------------------------------------------------------------------------
module vq_codebook_search #(
  parameter int NUM_CW = 16,
  parameter int DIM    = 13,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 4,
  parameter int DIST_W = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [ADDR_W-1:0]        cb_rd_addr,
  output logic                     cb_rd_en,
  input  logic signed [DATA_W-1:0] cb_rd_data,
  output logic                     busy,
  output logic [IDX_W-1:0]         res_idx,
  output logic [DIST_W-1:0]        res_dist,
  output logic                     res_valid,
  input  logic                     res_ready
);

  localparam int SQ_W  = 2*DATA_W + 1;
  localparam int DIM_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [DIM_W-1:0]  LAST_DIM  = DIM_W'(DIM-1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CW*DIM-1);

  typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIM_W-1:0]    d_q, d_d;
  logic [IDX_W-1:0]    cw_q, cw_d;

  logic                vld_p0;
  logic [DIM_W-1:0]    d_p0;
  logic [IDX_W-1:0]    cw_p0;

  logic [DIST_W-1:0]   acc_q;
  logic [DIST_W-1:0]   min_dist_q;
  logic [IDX_W-1:0]    min_idx_q;
  logic signed [DATA_W-1:0] vec_q [DIM];

  logic                accept;
  logic                last_sample;
  logic [SQ_W-1:0]     sq;
  logic [DIST_W-1:0]   cand;

  // Squared difference of two signed samples. The difference needs one
  // extra bit, and its square is always non-negative and fits SQ_W bits.
  function automatic logic [SQ_W-1:0] sq_diff(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0]     diff;
    logic signed [2*DATA_W+1:0] dx;
    logic signed [2*DATA_W+1:0] prod;
    diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    dx   = {{(DATA_W+1){diff[DATA_W]}}, diff};
    prod = dx * dx;
    return prod[SQ_W-1:0];
  endfunction

  assign accept      = (state_q == S_LOAD) && s_valid;
  assign last_sample = accept && (cnt_q == LAST_DIM);

  // FSM and address counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      cw_q    <= cw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    d_d     = d_q;
    cw_d    = cw_q;
    unique case (state_q)
      S_LOAD: begin
        if (last_sample) begin
          cnt_d   = '0;
          addr_d  = '0;
          d_d     = '0;
          cw_d    = '0;
          state_d = S_SEARCH;
        end else if (accept) begin
          cnt_d = cnt_q + DIM_W'(1);
        end
      end
      S_SEARCH: begin
        if (addr_q == LAST_ADDR) begin
          // Address wraps only when leaving the scan.
          addr_d  = '0;
          d_d     = '0;
          cw_d    = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (d_q == LAST_DIM) begin
            d_d  = '0;
            cw_d = cw_q + IDX_W'(1);
          end else begin
            d_d = d_q + DIM_W'(1);
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
    if (abort) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      addr_d  = '0;
      d_d     = '0;
      cw_d    = '0;
    end
  end

  // Sample buffer
  always_ff @(posedge clk) begin
    if (accept && !abort) vec_q[cnt_q] <= s_data;
  end

  // Stage p0: RAM read in flight, the dim/codeword tags travel with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      d_p0   <= '0;
      cw_p0  <= '0;
    end else if (abort) begin
      vld_p0 <= 1'b0;
      d_p0   <= '0;
      cw_p0  <= '0;
    end else begin
      vld_p0 <= (state_q == S_SEARCH);
      d_p0   <= d_q;
      cw_p0  <= cw_q;
    end
  end

  assign sq   = sq_diff(vec_q[d_p0], cb_rd_data);
  assign cand = acc_q + {{(DIST_W-SQ_W){1'b0}}, sq};

  // Stage p1: accumulate, compare at the end of each codeword
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      min_dist_q <= '0;
      min_idx_q  <= '0;
    end else if (abort) begin
      acc_q <= '0;
    end else if (last_sample) begin
      acc_q      <= '0;
      min_dist_q <= '1;
      min_idx_q  <= '0;
    end else if (vld_p0) begin
      if (d_p0 == LAST_DIM) begin
        acc_q <= '0;
        // Strict compare: an equal later codeword never displaces an earlier one.
        if (cand < min_dist_q) begin
          min_dist_q <= cand;
          min_idx_q  <= cw_p0;
        end
      end else begin
        acc_q <= cand;
      end
    end
  end

  assign s_ready    = (state_q == S_LOAD);
  assign busy       = (state_q == S_SEARCH) || (state_q == S_DRAIN);
  assign cb_rd_en   = (state_q == S_SEARCH);
  assign cb_rd_addr = addr_q;
  assign res_valid  = (state_q == S_DONE);
  assign res_idx    = res_valid ? min_idx_q  : '0;
  assign res_dist   = res_valid ? min_dist_q : '0;

endmodule
